// File: rtl/leglite_pkg.sv
// leglite_pkg -- shared definitions for the multi-cycle LEGLite core.
//   * opcode values of the 16-bit LEGLite encoding
//   * FSM state encoding
//   * instruction field bit positions
//   * sext7: sign-extends the 7-bit immediate to 64 bits; callers cast the
//     result down to DATA_W (DATA_W may range from 16 to 64)
package leglite_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_LD   = 3'b011;
  localparam logic [2:0] OP_ST   = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_CBZ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RS2_HI = 12;
  localparam int RS2_LO = 10;
  localparam int IMM_HI = 12;
  localparam int IMM_LO = 6;
  localparam int RS1_HI = 5;
  localparam int RS1_LO = 3;
  localparam int RD_HI  = 2;
  localparam int RD_LO  = 0;

  localparam int SEXT_MAX_W = 64;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Widest supported datapath; a DATA_W'() cast at the call site keeps the
  // low DATA_W bits, which is the correct sign extension for that width.
  function automatic logic signed [SEXT_MAX_W-1:0] sext7(input logic [6:0] imm);
    return {{(SEXT_MAX_W-7){imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/leglite_regfile.sv
// leglite_regfile -- LEGLite register file.
//   NREGS x DATA_W registers, two asynchronous read ports, one synchronous
//   write port. Asynchronous active-high reset clears every register.
// Ports:
//   clock, reset           clock / async reset
//   raddr1, rdata1         read port 1
//   raddr2, rdata2         read port 2
//   we, waddr, wdata       write port (rising edge)
module leglite_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [2:0]        raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/leglite_multicycle.sv
// leglite_multicycle -- multi-cycle LEGLite core with a DATA_W-wide datapath.
//   FETCH -> DECODE -> EXEC -> {MEM | WB | FETCH}; MEM -> {WB | FETCH};
//   WB -> FETCH; HALT is terminal until reset. Memories use ready handshakes.
// Ports:
//   clock, reset                  clock / async active-high reset
//   iaddr, ireq, idata, iready    instruction fetch handshake
//   daddr, dread, dwrite, dwdata  data access request (held until dready)
//   ddata, dready                 load data / access complete
//   alu_out                       ALUOut register (debug)
//   halted                        HALT has executed
//   retire_valid, retire_pc       only when LEGLITE_RETIRE_PORT_EN is defined
module leglite_multicycle
  import leglite_pkg::*;
#(
  parameter int              DATA_W = 16,
  parameter int              NREGS  = 8,
  parameter logic [DATA_W-1:0] PC_RST = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [DATA_W-1:0] iaddr,
  output logic              ireq,
  input  logic [15:0]       idata,
  input  logic              iready,
  output logic [DATA_W-1:0] daddr,
  output logic              dread,
  output logic              dwrite,
  output logic [DATA_W-1:0] dwdata,
  input  logic [DATA_W-1:0] ddata,
  input  logic              dready,
  output logic [DATA_W-1:0] alu_out,
`ifdef LEGLITE_RETIRE_PORT_EN
  output logic              halted,
  output logic              retire_valid,
  output logic [DATA_W-1:0] retire_pc
`else
  output logic              halted
`endif
);

  state_t state, next_state;

  logic        [DATA_W-1:0] pc, pcir, a, b, alu_q, mdr;
  logic        [15:0]       ir;
  logic signed [DATA_W-1:0] imm;
  logic        [DATA_W-1:0] alu_res;
  logic        [DATA_W-1:0] rdata1, rdata2, wb_data;
  logic        [2:0]        op, rs1, rs2, rd, raddr2;
  logic                     rf_we;

  assign op  = ir[OP_HI:OP_LO];
  assign rs1 = ir[RS1_HI:RS1_LO];
  assign rs2 = ir[RS2_HI:RS2_LO];
  assign rd  = ir[RD_HI:RD_LO];
  assign imm = DATA_W'(sext7(ir[IMM_HI:IMM_LO]));

  // ST and CBZ read their data/test register from the rd/rt field.
  assign raddr2  = (op == OP_ST || op == OP_CBZ) ? rd : rs2;
  assign wb_data = (op == OP_LD) ? mdr : alu_q;

  leglite_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .raddr1 (rs1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (wb_data)
  );

  // CBZ computes its branch target on the ALU so ALUOut reflects it too.
  always_comb begin
    alu_res = a + imm;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_CBZ:  alu_res = pcir + imm;
      default: alu_res = a + imm;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ireq       = 1'b0;
    dread      = 1'b0;
    dwrite     = 1'b0;
    rf_we      = 1'b0;
    case (state)
      ST_FETCH: begin
        ireq = 1'b1;
        if (iready) next_state = ST_DECODE;
      end
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_LD, OP_ST: next_state = ST_MEM;
          OP_CBZ:       next_state = ST_FETCH;
          OP_HALT:      next_state = ST_HALT;
          default:      next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        dread  = (op == OP_LD);
        dwrite = (op == OP_ST);
        if (dready) next_state = (op == OP_LD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        rf_we      = 1'b1;
        next_state = ST_FETCH;
      end
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_FETCH;
    endcase
    // Requests must fall the instant reset rises, not at the next edge.
    if (reset) begin
      ireq   = 1'b0;
      dread  = 1'b0;
      dwrite = 1'b0;
      rf_we  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc    <= PC_RST;
      pcir  <= '0;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      alu_q <= '0;
      mdr   <= '0;
    end else begin
      case (state)
        ST_FETCH: if (iready) begin
          ir   <= idata;
          pcir <= pc;
          pc   <= pc + 1'b1;
        end
        ST_DECODE: begin
          a <= rdata1;
          b <= rdata2;
        end
        ST_EXEC: begin
          alu_q <= alu_res;
          if (op == OP_CBZ && b == '0) pc <= alu_res;
        end
        ST_MEM: if (dready && op == OP_LD) mdr <= ddata;
        default: ;
      endcase
    end
  end

  assign iaddr   = pc;
  assign daddr   = alu_q;
  assign dwdata  = b;
  assign alu_out = alu_q;
  assign halted  = (state == ST_HALT);

`ifdef LEGLITE_RETIRE_PORT_EN
  assign retire_valid = !reset &&
                        ((state == ST_WB) ||
                         (state == ST_MEM && op == OP_ST && dready) ||
                         (state == ST_EXEC && (op == OP_CBZ || op == OP_HALT)));
  assign retire_pc    = pcir;
`endif

endmodule

// File: tb/tb_leglite_multicycle.sv
// tb_leglite_multicycle -- directed self-checking bench for leglite_multicycle.
// Override DATA_W (e.g. 32) to rerun the same sequence on a wider datapath.
module tb_leglite_multicycle;

  parameter int DATA_W = 16;
  localparam logic [DATA_W-1:0] PC_RST = '0;
  localparam logic [63:0] ONES = (64'd1 << DATA_W) - 64'd1;
  localparam logic [63:0] W1   = (64'd6 - 64'd63) & ONES;

  logic              clock = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] iaddr;
  logic              ireq;
  logic [15:0]       idata;
  logic              iready;
  logic [DATA_W-1:0] daddr;
  logic              dread;
  logic              dwrite;
  logic [DATA_W-1:0] dwdata;
  logic [DATA_W-1:0] ddata;
  logic              dready;
  logic [DATA_W-1:0] alu_out;
  logic              halted;
`ifdef LEGLITE_RETIRE_PORT_EN
  logic              retire_valid;
  logic [DATA_W-1:0] retire_pc;
  logic [63:0]       retired[$];
  logic [63:0]       exp_ret[15];
`endif

  int checks   = 0;
  int failures = 0;

  leglite_multicycle #(.DATA_W(DATA_W), .NREGS(8), .PC_RST(PC_RST)) dut (
    .clock   (clock),
    .reset   (reset),
    .iaddr   (iaddr),
    .ireq    (ireq),
    .idata   (idata),
    .iready  (iready),
    .daddr   (daddr),
    .dread   (dread),
    .dwrite  (dwrite),
    .dwdata  (dwdata),
    .ddata   (ddata),
    .dready  (dready),
    .alu_out (alu_out),
`ifdef LEGLITE_RETIRE_PORT_EN
    .halted       (halted),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc)
`else
    .halted  (halted)
`endif
  );

  always #5 clock = ~clock;

`ifdef LEGLITE_RETIRE_PORT_EN
  always @(negedge clock) if (retire_valid) retired.push_back(64'(retire_pc));
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Enter in FETCH; leaves the core in DECODE.
  task automatic fetch(input logic [15:0] instr, input int waits);
    logic [63:0] pc0;
    pc0 = 64'(iaddr);
    check("fetch_ireq", 64'(ireq), 64'd1);
    for (int i = 0; i < waits; i++) begin
      tick();
      check("fetch_wait_iaddr", 64'(iaddr), pc0);
      check("fetch_wait_ireq", 64'(ireq), 64'd1);
    end
    idata  = instr;
    iready = 1'b1;
    tick();
    iready = 1'b0;
    idata  = 16'h0000;
    check("decode_ireq", 64'(ireq), 64'd0);
  endtask

  task automatic alu_op(input logic [15:0] instr, input logic [63:0] exp_alu,
                        input logic [63:0] exp_next);
    fetch(instr, 0);
    tick();
    tick();
    check("wb_ireq", 64'(ireq), 64'd0);
    tick();
    check("alu_out", 64'(alu_out), exp_alu);
    check("alu_next_iaddr", 64'(iaddr), exp_next);
    check("alu_next_ireq", 64'(ireq), 64'd1);
  endtask

  task automatic cbz(input logic [15:0] instr, input logic [63:0] exp_next);
    fetch(instr, 0);
    tick();
    check("cbz_exec_ireq", 64'(ireq), 64'd0);
    tick();
    check("cbz_ireq", 64'(ireq), 64'd1);
    check("cbz_next_iaddr", 64'(iaddr), exp_next);
  endtask

  initial begin
    reset  = 1'b1;
    idata  = 16'h0000;
    iready = 1'b0;
    ddata  = '0;
    dready = 1'b0;
    #2;
    check("rst_ireq", 64'(ireq), 64'd0);
    check("rst_dread", 64'(dread), 64'd0);
    check("rst_dwrite", 64'(dwrite), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_alu_out", 64'(alu_out), 64'd0);
    check("rst_iaddr", 64'(iaddr), 64'(PC_RST));
    tick();
    reset = 1'b0;
    #1;
    check("rel_ireq", 64'(ireq), 64'd1);

    // ADDI R1,R0,5 at PC0, zero wait: 4 cycles
    alu_op(16'hA141, 64'd5, 64'd1);

    // ST R1,[R0+3] with one data wait cycle
    fetch(16'h80C1, 0);
    tick();
    tick();
    check("st_dwrite", 64'(dwrite), 64'd1);
    check("st_dread", 64'(dread), 64'd0);
    check("st_daddr", 64'(daddr), 64'd3);
    check("st_dwdata", 64'(dwdata), 64'd5);
    tick();
    check("st_hold_dwrite", 64'(dwrite), 64'd1);
    check("st_hold_daddr", 64'(daddr), 64'd3);
    check("st_hold_dwdata", 64'(dwdata), 64'd5);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    check("st_done_dwrite", 64'(dwrite), 64'd0);
    check("st_next_iaddr", 64'(iaddr), 64'd2);

    // LD R1,[R0+7] with three data wait cycles: 8 cycles total
    fetch(16'h61C1, 0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ld_dread", 64'(dread), 64'd1);
      check("ld_daddr", 64'(daddr), 64'd7);
      if (i == 3) begin
        dready = 1'b1;
        ddata  = DATA_W'(16'h7FFF);
      end
      tick();
    end
    dready = 1'b0;
    ddata  = '0;
    check("ld_wb_dread", 64'(dread), 64'd0);
    check("ld_wb_ireq", 64'(ireq), 64'd0);
    tick();
    check("ld_next_iaddr", 64'(iaddr), 64'd3);
    check("ld_next_ireq", 64'(ireq), 64'd1);

    // ADDI R2,R0,1 with two fetch wait states; stray dready must be ignored
    dready = 1'b1;
    fetch(16'hA042, 2);
    tick();
    tick();
    tick();
    dready = 1'b0;
    check("addi2_alu_out", 64'(alu_out), 64'd1);
    check("addi2_iaddr", 64'(iaddr), 64'd4);

    alu_op(16'h080B, 64'h8000, 64'd5);   // ADD R3=R1+R2 -> 0x8000
    alu_op(16'h2804, ONES, 64'd6);       // SUB R4=R0-R2 -> all ones
    alu_op(16'h501D, 64'h8000, 64'd7);   // AND R5=R3&R4 -> 0x8000

    cbz(16'hDF80, 64'd5);                // R0==0, taken: 7-2
    cbz(16'hDF82, 64'd6);                // R2==1, not taken
    cbz(16'hD040, W1);                   // 6-63 wraps below zero
    cbz(16'hCFC0, 64'd6);                // +63 wraps back above top
    cbz(16'hDE40, ONES);                 // 6-7 -> last address
    alu_op(16'hA086, 64'd2, 64'd0);      // PC wraps from max to 0

    // Reset in the middle of a load access
    fetch(16'h61C1, 0);
    tick();
    tick();
    check("mid_dread", 64'(dread), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_dread", 64'(dread), 64'd0);
    check("mid_rst_ireq", 64'(ireq), 64'd0);
    check("mid_rst_alu_out", 64'(alu_out), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_iaddr", 64'(iaddr), 64'(PC_RST));
    check("post_rst_ireq", 64'(ireq), 64'd1);

    // Registers cleared: storing R1 must write 0
    fetch(16'h80C1, 0);
    tick();
    tick();
    check("post_st_dwrite", 64'(dwrite), 64'd1);
    check("post_st_daddr", 64'(daddr), 64'd3);
    check("post_st_dwdata", 64'(dwdata), 64'd0);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    check("post_st_iaddr", 64'(iaddr), 64'd1);

    // HALT, with fetch responses offered that must be ignored
    fetch(16'hE000, 0);
    tick();
    tick();
    iready = 1'b1;
    idata  = 16'hA141;
    for (int i = 0; i < 22; i++) begin
      check("halt_halted", 64'(halted), 64'd1);
      check("halt_ireq", 64'(ireq), 64'd0);
      check("halt_iaddr", 64'(iaddr), 64'd2);
      tick();
    end
    iready = 1'b0;
    idata  = 16'h0000;

`ifdef LEGLITE_RETIRE_PORT_EN
    exp_ret = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7,
                64'd5, 64'd6, W1, 64'd6, ONES, 64'd0, 64'd1};
    check("retire_count", 64'(retired.size()), 64'd15);
    for (int i = 0; i < 15; i++) begin
      if (i < retired.size()) check("retire_pc", retired[i], exp_ret[i]);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
